modexp_arbiter: RTL

//  Shares one mont_modexp engine among NREQ requesters. Round-robin arbitration

---
 rtl/modexp_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/modexp_arbiter.sv
// modexp_arbiter: round-robin front end that shares one modexp engine among
// NREQ requesters. One job in flight; the result returns on a single tagged
// response channel.
module modexp_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_base,
    input  logic [NREQ*WIDTH-1:0] req_exp,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_data,
    output logic                  eng_start,
    output logic [WIDTH-1:0]      eng_base,
    output logic [WIDTH-1:0]      eng_exp,
    input  logic                  eng_done,
    input  logic [WIDTH-1:0]      eng_result,
    output logic                  busy,
    output logic [15:0]           job_count
);

    typedef enum logic [1:0] {ARB, RUN, RESP} state_t;

    state_t         state, state_nx;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_any;
    logic           grant;

    // Search for the first valid requester at or after ptr, wrapping at NREQ.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
    end

    // Grant only from ARB, and never while the engine is still clearing done.
    // Gated with rst_n so nothing is acknowledged while reset is held.
    assign grant = rst_n && (state == ARB) && !eng_done && gnt_any;

    // Next-state and handshake outputs.
    always_comb begin
        state_nx   = state;
        req_ready  = '0;
        eng_start  = 1'b0;
        resp_valid = 1'b0;
        busy       = (state != ARB);
        case (state)
            ARB: begin
                if (grant) begin
                    req_ready[gnt_idx] = 1'b1;
                    state_nx           = RUN;
                end
            end
            RUN: begin
                eng_start = 1'b1;
                if (eng_done) state_nx = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nx = ARB;
            end
            default: state_nx = ARB;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARB;
        else        state <= state_nx;
    end

    // Job registers: operands and tag latched at grant, result at done,
    // pointer advances past the granted requester, count on response accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            eng_base  <= '0;
            eng_exp   <= '0;
            resp_id   <= '0;
            resp_data <= '0;
            job_count <= '0;
        end else begin
            if (grant) begin
                eng_base <= req_base[gnt_idx*WIDTH +: WIDTH];
                eng_exp  <= req_exp[gnt_idx*WIDTH +: WIDTH];
                resp_id  <= gnt_idx;
                ptr      <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
            end
            if (state == RUN && eng_done) resp_data <= eng_result;
            if (state == RESP && resp_ready) job_count <= job_count + 16'd1;
        end
    end

endmodule
